score_renderer: RTL and testbench

Consumes the 90-bit three-digit score bitmap produced by the score-to-bitmap stage and draws it into the VGA frame buffer, one pixel per accepted cycle. It walks 3 digits × 5 rows × 6 columns under a small FSM and emits x/y/colour/plot writes to the VGA adapter. A ready handshake provides backpressure. The block sits between the score bitmap generator and the frame-buffer write arbiter.

---
 rtl/score_renderer.sv | 137 +++++++++++++
 tb/tb_score_renderer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/score_renderer.sv
// Draws a latched three-digit 6x5 score bitmap into the frame buffer, one pixel
// per accepted cycle, walking digit/row/column with all outputs registered.
module score_renderer #(
    parameter int         X0        = 4,
    parameter int         Y0        = 2,
    parameter logic [2:0] FG_COLOUR = 3'b111,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [89:0] bitmap,
    input  logic        ready,
    output logic        busy,
    output logic        done,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot
);

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    state_t      state, state_n;
    logic [89:0] shadow, shadow_n;
    logic [1:0]  d, d_n;
    logic [2:0]  r, r_n, c, c_n;
    logic [7:0]  x_n;
    logic [6:0]  y_n;
    logic [2:0]  colour_n;
    logic        plot_n, busy_n, done_n;

    // Digit d=0 (hundreds) lives in the top 30 bits; bit 5 of a row is its leftmost column.
    function automatic logic [6:0] bit_index(input logic [1:0] dd, input logic [2:0] rr,
                                             input logic [2:0] cc);
        return 7'd65 - 7'd30 * {5'b0, dd} + 7'd6 * {4'b0, rr} - {4'b0, cc};
    endfunction

    function automatic logic [2:0] pick_colour(input logic b);
        return b ? FG_COLOUR : BG_COLOUR;
    endfunction

    function automatic logic [7:0] pixel_x(input logic [1:0] dd, input logic [2:0] cc);
        return 8'(X0) + 8'd6 * {6'b0, dd} + {5'b0, cc};
    endfunction

    function automatic logic [6:0] pixel_y(input logic [2:0] rr);
        return 7'(Y0) + {4'b0, rr};
    endfunction

    always_comb begin
        state_n  = state;
        shadow_n = shadow;
        d_n      = d;
        r_n      = r;
        c_n      = c;
        x_n      = x;
        y_n      = y;
        colour_n = colour;
        plot_n   = plot;
        busy_n   = busy;
        done_n   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n  = DRAW;
                    shadow_n = bitmap;
                    d_n      = 2'd0;
                    r_n      = 3'd0;
                    c_n      = 3'd0;
                    plot_n   = 1'b1;
                    busy_n   = 1'b1;
                    x_n      = pixel_x(2'd0, 3'd0);
                    y_n      = pixel_y(3'd0);
                    // Shadow is being loaded on this edge, so the first pixel reads the input.
                    colour_n = pick_colour(bitmap[bit_index(2'd0, 3'd0, 3'd0)]);
                end
            end
            DRAW: begin
                if (ready) begin
                    if (d == 2'd2 && r == 3'd4 && c == 3'd5) begin
                        state_n = DONE;
                        plot_n  = 1'b0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        if (c == 3'd5) begin
                            c_n = 3'd0;
                            if (r == 3'd4) begin
                                r_n = 3'd0;
                                d_n = d + 2'd1;
                            end else begin
                                r_n = r + 3'd1;
                            end
                        end else begin
                            c_n = c + 3'd1;
                        end
                        x_n      = pixel_x(d_n, c_n);
                        y_n      = pixel_y(r_n);
                        colour_n = pick_colour(shadow[bit_index(d_n, r_n, c_n)]);
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            shadow <= '0;
            d      <= '0;
            r      <= '0;
            c      <= '0;
            x      <= '0;
            y      <= '0;
            colour <= '0;
            plot   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            shadow <= shadow_n;
            d      <= d_n;
            r      <= r_n;
            c      <= c_n;
            x      <= x_n;
            y      <= y_n;
            colour <= colour_n;
            plot   <= plot_n;
            busy   <= busy_n;
            done   <= done_n;
        end
    end

endmodule

// File: tb/tb_score_renderer.sv
// Directed bench for score_renderer: full passes, backpressure, ignored starts,
// bitmap latching and mid-pass reset.
module tb_score_renderer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [89:0] bitmap;
    logic        ready;
    logic        busy, done, plot;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;

    int checks = 0;
    int errors = 0;

    logic [2:0] cap  [0:31][0:15];
    int         hits [0:31][0:15];

    score_renderer dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .bitmap (bitmap),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .x      (x),
        .y      (y),
        .colour (colour),
        .plot   (plot)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_hits();
        for (int i = 0; i < 32; i++)
            for (int j = 0; j < 16; j++) begin
                cap[i][j]  = 3'd0;
                hits[i][j] = 0;
            end
    endtask

    // One pass: start at E0, then follow pixels p; stall/extra-start/abort are optional.
    task automatic run_pass(input logic [89:0] bm, input logic [89:0] bm_after,
                            input int stall_px, input int stall_len,
                            input bit extra_start, input int abort_px);
        int p, k, stalled, idx, ed, er, ec;
        logic rdy, was_plot;
        bit finished;
        bitmap = bm;
        start  = 1'b1;
        ready  = 1'b1;
        step();
        start  = 1'b0;
        bitmap = bm_after;
        p = 0; k = 0; stalled = 0; finished = 0;
        while (k < 300 && !finished) begin
            if (abort_px >= 0 && p == abort_px) begin
                check("pre_abort_plot", plot, 1);
                reset = 1'b1;
                #1;
                check("abort_plot", plot, 0);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                check("abort_x", x, 0);
                check("abort_y", y, 0);
                step();
                reset = 1'b0;
                for (int n = 0; n < 4; n++) begin
                    step();
                    check("post_abort_idle_plot", plot, 0);
                end
                return;
            end
            if (done) begin
                check("done_cycle", k, 90 + stall_len);
                check("pixels_accepted", p, 90);
                check("done_plot", plot, 0);
                check("done_busy", busy, 0);
                start = extra_start;
                step();
                start = 1'b0;
                check("done_single_pulse", done, 0);
                step();
                step();
                check("no_restart_plot", plot, 0);
                check("no_restart_busy", busy, 0);
                finished = 1;
            end else begin
                ed = p / 30; er = (p % 30) / 6; ec = p % 6;
                idx = 30 * (2 - ed) + 6 * er + 5 - ec;
                check("plot", plot, 1);
                check("busy", busy, 1);
                check("x", x, 4 + 6 * ed + ec);
                check("y", y, 2 + er);
                check("colour", colour, bm[idx] ? 3'b111 : 3'b000);
                if (x < 32 && y < 16) begin
                    cap[x][y] = colour;
                    if (!(p == stall_px && stalled > 0)) hits[x][y]++;
                end
                rdy = !(p == stall_px && stalled < stall_len);
                if (!rdy) stalled++;
                ready = rdy;
                start = extra_start && p == 20;
                was_plot = plot;
                step();
                start = 1'b0;
                ready = 1'b1;
                if (was_plot && rdy) p++;
                k++;
            end
        end
        if (!finished) check("pass_timeout", k, 0);
    endtask

    initial begin
        int good;
        logic [89:0] bm;
        reset  = 1'b1;
        start  = 1'b0;
        ready  = 1'b1;
        bitmap = '0;
        step();
        step();
        check("rst_plot", plot, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_colour", colour, 0);
        reset = 1'b0;
        step();
        check("idle_plot", plot, 0);

        // Ones digit "0": only top row of ones matters for the directed pixels.
        clear_hits();
        bm = '0;
        bm[5:0]   = 6'b001100;
        bm[11:6]  = 6'b010010;
        bm[17:12] = 6'b010010;
        bm[23:18] = 6'b010010;
        bm[29:24] = 6'b001100;
        run_pass(bm, bm, -1, 0, 1'b0, -1);
        check("t1_x16", cap[16][2], 3'b000);
        check("t1_x17", cap[17][2], 3'b000);
        check("t1_x18", cap[18][2], 3'b111);
        check("t1_x19", cap[19][2], 3'b111);
        check("t1_x20", cap[20][2], 3'b000);
        check("t1_x21", cap[21][2], 3'b000);
        check("t1_hundreds", cap[4][2], 3'b000);
        check("t1_tens", cap[12][4], 3'b000);

        // All ones: each coordinate in 4..21 x 2..6 hit exactly once.
        clear_hits();
        run_pass({90{1'b1}}, {90{1'b1}}, -1, 0, 1'b0, -1);
        good = 0;
        for (int i = 4; i <= 21; i++)
            for (int j = 2; j <= 6; j++)
                if (hits[i][j] == 1 && cap[i][j] == 3'b111) good++;
        check("t2_coverage", good, 90);

        // Backpressure on pixel 10 (x=8,y=3) for 3 cycles.
        clear_hits();
        run_pass({90{1'b1}}, {90{1'b1}}, 10, 3, 1'b0, -1);
        check("t3_px10_once", hits[8][3], 1);

        // Extra start pulses during the pass and during DONE.
        run_pass(bm, bm, -1, 0, 1'b1, -1);

        // Bitmap cleared right after latch: tens digit all set must still draw.
        clear_hits();
        bm = '0;
        bm[59:30] = {30{1'b1}};
        run_pass(bm, '0, -1, 0, 1'b0, -1);
        check("t5_tens_fg", cap[10][2], 3'b111);
        check("t5_hund_bg", cap[4][2], 3'b000);

        // Reset at pixel 40, then a clean full pass from (4,2).
        run_pass({90{1'b1}}, {90{1'b1}}, -1, 0, 1'b0, 40);
        run_pass(bm, bm, -1, 0, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
